// File: rtl/result_display_mux.sv
// Latches the 5-bit adder result and scans it in decimal across a 4-digit
// common-anode seven-segment display. Segments and anodes are active-low.
module result_display_mux #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [4:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;
    localparam logic [6:0]       SEG_C     = 7'b1000110;

    logic [4:0]       value_q,  value_d;
    logic             loaded_q, loaded_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       idx_q,    idx_d;
    logic [3:0]       an_q,     an_d;
    logic [6:0]       seg_q,    seg_d;

    logic [1:0]       tens;
    logic [3:0]       ones;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'b1000000;
            4'd1:    seg_digit = 7'b1111001;
            4'd2:    seg_digit = 7'b0100100;
            4'd3:    seg_digit = 7'b0110000;
            4'd4:    seg_digit = 7'b0011001;
            4'd5:    seg_digit = 7'b0010010;
            4'd6:    seg_digit = 7'b0000010;
            4'd7:    seg_digit = 7'b1111000;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0010000;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    // Value never exceeds 31, so range compares replace a general divider.
    always_comb begin
        tens = 2'd0;
        ones = 4'(value_q);
        if (value_q >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(value_q - 5'd30);
        end else if (value_q >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(value_q - 5'd20);
        end else if (value_q >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(value_q - 5'd10);
        end
    end

    always_comb begin
        value_d  = value_q;
        loaded_d = loaded_q;
        if (load) begin
            value_d  = {cout, sum};
            loaded_d = 1'b1;
        end

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        an_d = ~(4'b0001 << idx_q);

        seg_d = SEG_BLANK;
        if (!loaded_q) begin
            seg_d = SEG_DASH;
        end else begin
            case (idx_q)
                2'd0:    seg_d = seg_digit(ones);
                2'd1:    seg_d = (tens == 2'd0) ? SEG_BLANK : seg_digit({2'b00, tens});
                2'd2:    seg_d = SEG_BLANK;
                default: seg_d = value_q[4] ? SEG_C : SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q  <= '0;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= '1;
        end else begin
            value_q  <= value_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign value = value_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_result_display_mux.sv
// Scoreboard bench: stimulus queues the expected display frames, a monitor
// pops one entry each time the visible {an,seg} changes.
module tb_result_display_mux;

    localparam logic [6:0] BL   = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] SC   = 7'b1000110;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000, D5 = 7'b0010010, D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000, D9 = 7'b0010000;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [4:0] value;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       cout = 1'b0;
    logic [4:0] value;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;

    result_display_mux #(.REFRESH_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .sum(sum), .cout(cout),
        .value(value), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int k);
        while (ecnt < k) step();
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic [4:0] v, input string n);
        exp_t e;
        e.an = a; e.seg = s; e.value = v; e.name = n;
        sb.push_back(e);
    endtask

    // Issue a load so that it is captured on edge k.
    task automatic load_at(input int k, input logic c, input logic [3:0] s);
        run_to(k - 1);
        cout = c; sum = s; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Monitor: one scoreboard entry per visible change, plus per-digit hold check.
    logic [10:0] prev;
    logic [3:0]  prev_an;
    int          runlen = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if ({an, seg} !== prev) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: an=%b seg=%b value=%0d, required no change", an, seg, value);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    total++;
                    if ({an, seg, dp, value} !== {e.an, e.seg, 1'b1, e.value}) begin
                        bad++;
                        $display("FAIL %s: got an=%b seg=%b dp=%b value=%0d, required an=%b seg=%b dp=1 value=%0d",
                                 e.name, an, seg, dp, value, e.an, e.seg, e.value);
                    end
                end
            end
            if (an !== prev_an) begin
                if (an === {prev_an[2:0], prev_an[3]}) begin
                    total++;
                    if (runlen != 4) begin
                        bad++;
                        $display("FAIL hold_len: digit an=%b held %0d cycles, required 4", prev_an, runlen);
                    end
                end
                runlen = 1;
            end else begin
                runlen++;
            end
            prev    = {an, seg};
            prev_an = an;
            if (done) begin
                total++;
                if (sb.size() != 0) begin
                    bad++;
                    $display("FAIL sb_drain: %0d expected frames never seen, required 0", sb.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        push(4'b1111, BL, 5'd0, "reset_state");
        mon_en = 1'b1;
        step(); step();

        // No load yet: dashes on every digit for two full rotations.
        for (int r = 0; r < 2; r++) begin
            push(4'b1110, DASH, 5'd0, "dash_an0");
            push(4'b1101, DASH, 5'd0, "dash_an1");
            push(4'b1011, DASH, 5'd0, "dash_an2");
            push(4'b0111, DASH, 5'd0, "dash_an3");
        end
        ecnt = 0;
        rst_n = 1'b1;

        // Loads below land on refresh-wrap edges (multiples of 4).
        push(4'b1110, D7, 5'd7, "v7_an0");
        push(4'b1101, BL, 5'd7, "v7_an1");
        push(4'b1011, BL, 5'd7, "v7_an2");
        push(4'b0111, BL, 5'd7, "v7_an3");
        load_at(32, 1'b0, 4'b0111);

        push(4'b1110, D1, 5'd31, "v31_an0");
        push(4'b1101, D3, 5'd31, "v31_an1");
        push(4'b1011, BL, 5'd31, "v31_an2");
        push(4'b0111, SC, 5'd31, "v31_an3");
        load_at(48, 1'b1, 4'b1111);

        push(4'b1110, D0, 5'd10, "v10_an0");
        push(4'b1101, D1, 5'd10, "v10_an1");
        push(4'b1011, BL, 5'd10, "v10_an2");
        push(4'b0111, BL, 5'd10, "v10_an3");
        load_at(64, 1'b0, 4'b1010);

        push(4'b1110, D6, 5'd16, "v16_an0");
        push(4'b1101, D1, 5'd16, "v16_an1");
        push(4'b1011, BL, 5'd16, "v16_an2");
        push(4'b0111, SC, 5'd16, "v16_an3");
        load_at(80, 1'b1, 4'b0000);

        // Back-to-back mid-digit loads 5 then 9 on edges 98 and 99.
        push(4'b1110, D6, 5'd16, "b2b_frame_start");
        push(4'b1110, D5, 5'd9,  "b2b_show5");
        push(4'b1110, D9, 5'd9,  "b2b_show9");
        push(4'b1101, BL, 5'd9,  "v9_an1");
        push(4'b1011, BL, 5'd9,  "v9_an2");
        push(4'b0111, BL, 5'd9,  "v9_an3");
        run_to(97);
        cout = 1'b0; sum = 4'd5; load = 1'b1;
        step();
        sum = 4'd9;
        step();
        load = 1'b0;

        // Load 23, then a one-cycle reset in the middle of the an1 digit.
        push(4'b1110, D3, 5'd23, "v23_an0");
        push(4'b1101, D2, 5'd23, "v23_an1");
        push(4'b1111, BL, 5'd0,  "midscan_reset");
        push(4'b1110, DASH, 5'd0, "post_reset_an0");
        push(4'b1101, DASH, 5'd0, "post_reset_an1");
        push(4'b1011, DASH, 5'd0, "post_reset_an2");
        push(4'b0111, DASH, 5'd0, "post_reset_an3");
        push(4'b1110, DASH, 5'd0, "post_reset_wrap");
        load_at(112, 1'b1, 4'b0111);
        run_to(117);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_to(138);
        done = 1'b1;
    end

endmodule
